seq_mult_ctrl: RTL and testbench

//   Sequential shift-add multiplier controller with its datapath registers. It sequences one

---
 rtl/seq_mult_ctrl_pkg.sv | 14 +
 rtl/seq_mult_ctrl_fsm.sv | 75 +++++++
 rtl/seq_mult_ctrl.sv | 73 +++++++
 tb/tb_seq_mult_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encoding,
// default operand width and the ALU opcode this block serves.
package seq_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mult_state_e;

    localparam int         MULT_WIDTH  = 32;
    localparam logic [3:0] ALU_OP_MULT = 4'd3;

endpackage

// File: rtl/seq_mult_ctrl_fsm.sv
// Control FSM for the shift-add multiplier: iteration counter, start/busy/done
// handshake and the load/shift/capture enables for the datapath in the top level.
//
//   state  | meaning
//   S_IDLE | waiting for start; product holds
//   S_RUN  | one add/shift iteration per cycle, WIDTH cycles
//   S_DONE | product valid, done pulse, back to idle
module seq_mult_fsm
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    output logic load_o,
    output logic shift_o,
    output logic capture_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    // Unreachable encoding 2'd3 recovers to idle.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign load_o    = (state_q == S_IDLE) && start_i;
    assign shift_o   = (state_q == S_RUN);
    assign capture_o = shift_o && (cnt_q == LAST_CNT);

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier: operand/accumulator/product
// registers and the shared adder, sequenced by seq_mult_fsm.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic               load;
    logic               shift;
    logic               capture;

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     upper;

    seq_mult_fsm #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .busy_o   (busy),
        .done_o   (done),
        .load_o   (load),
        .shift_o  (shift),
        .capture_o(capture)
    );

    // The adder carry is kept and shifted into the MSB; dropping it breaks all-ones operands.
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        upper = acc_q[0] ? sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        acc_d = {upper, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            if (load) begin
                mcand_q <= a;
                acc_q   <= {{WIDTH{1'b0}}, b};
            end else if (shift) begin
                acc_q <= acc_d;
            end
            // Final iteration result goes straight to product so it is valid with done.
            if (capture) begin
                product_q <= acc_d;
            end
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: directed corner cases plus random operands
// compared against plain 64-bit multiplication.
module tb_seq_mult_ctrl;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_mult_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    endfunction

    // Pulse start for one cycle, scramble a/b after capture, wait for done.
    // lat = number of negedges after the start edge until done is first seen (0 on timeout).
    task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [2*W-1:0] res, output int lat, output logic busy_first);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        busy_first = busy;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = 0;
        res = product;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b product=%h required 0/0/0", busy, done, product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [2*W-1:0] res;
        int lat;
        logic bf;
        do_mult(32'd5, 32'd7, res, lat, bf);
        checks++;
        if (bf !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b after start, required 1", bf);
        end
        checks++;
        if (lat != W + 1) begin
            errors++;
            $display("FAIL basic_latency: %0d cycles, required %0d", lat, W + 1);
        end
        checks++;
        if (res !== 64'd35) begin
            errors++;
            $display("FAIL basic_product: %h required %h", res, 64'd35);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: busy=%b done=%b required 0/0", busy, done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (product !== 64'd35) begin
            errors++;
            $display("FAIL basic_hold: product=%h required %h", product, 64'd35);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0]   xs [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1231_1111};
        logic [W-1:0]   ys [3] = '{32'hFFFF_FFFF, 32'h1231_1111, 32'h1};
        logic [2*W-1:0] want [3] = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h0000_0000_1231_1111};
        logic [2*W-1:0] res;
        int lat;
        logic bf;
        for (int i = 0; i < 3; i++) begin
            do_mult(xs[i], ys[i], res, lat, bf);
            checks++;
            if (lat != W + 1 || res !== want[i]) begin
                errors++;
                $display("FAIL corner%0d: product=%h lat=%0d required %h lat=%0d",
                         i, res, lat, want[i], W + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] res;
        int lat;
        logic bf;
        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 5 == 0) x = x >> $urandom_range(0, 31);
            do_mult(x, y, res, lat, bf);
            checks++;
            if (lat != W + 1 || res !== ref_mul(x, y)) begin
                errors++;
                $display("FAIL random%0d: a=%h b=%h product=%h lat=%0d required %h lat=%0d",
                         i, x, y, res, lat, ref_mul(x, y), W + 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        @(negedge clk);
        start = 1'b1;
        a = 32'd3;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                checks++;
                if (product !== 64'd9) begin
                    errors++;
                    $display("FAIL ignore_product: %h required %h", product, 64'd9);
                end
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL ignore_done_count: %0d required 1", n_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] res;
        int lat;
        int n_done = 0;
        logic bf;
        @(negedge clk);
        start = 1'b1;
        a = 32'd6;
        b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b product=%h required 0/0/0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d active cycles after release, required 0", n_done);
        end
        do_mult(32'd6, 32'd6, res, lat, bf);
        checks++;
        if (lat != W + 1 || res !== 64'd36) begin
            errors++;
            $display("FAIL reset_mid_rerun: product=%h lat=%0d required %h lat=%0d", res, lat, 64'd36, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        int stamps[$];
        @(negedge clk);
        start = 1'b1;
        a = 32'd2;
        b = 32'd4;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (done) begin
                stamps.push_back(c);
                checks++;
                if (product !== 64'd8) begin
                    errors++;
                    $display("FAIL b2b_product: %h required %h", product, 64'd8);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (stamps.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d dones required 3", stamps.size());
        end else begin
            checks++;
            if (stamps[0] != W || stamps[1] - stamps[0] != W + 2 || stamps[2] - stamps[1] != W + 2) begin
                errors++;
                $display("FAIL b2b_spacing: at %0d,%0d,%0d required %0d then every %0d",
                         stamps[0], stamps[1], stamps[2], W, W + 2);
            end
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
